alu8_exec_unit: RTL and testbench

- 8-bit execute stage of the C0 microarchitecture.
- Selects the B operand from the 8-entry register bank or from an immediate, then computes one of 10 ALU operations on A and B.
- Drives a combinational result back to the register bank write port.
- Holds a registered flags byte, updated on the rising edge of clk.

---
 rtl/alu8_pkg.sv | 25 ++
 rtl/alu8_exec_unit_if.sv | 24 ++
 rtl/alu8_bsel.sv | 16 +
 rtl/alu8_exec_unit.sv | 114 +++++++++++
 tb/tb_alu8_exec_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/alu8_pkg.sv
// rtl/alu8_pkg.sv - shared widths, opcode codes and flag bit positions for the C0 execute stage
package alu8_pkg;
  localparam int W      = 8;
  localparam int NREG   = 8;
  localparam int BSEL_W = $clog2(NREG);

  // Full 4-bit codes where bit 3 distinguishes the operation
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b1011;

  // Low-field codes where bit 3 is don't-care
  localparam logic [2:0] OPL_XOR = 3'b001;
  localparam logic [2:0] OPL_AND = 3'b010;
  localparam logic [2:0] OPL_SHL = 3'b100;
  localparam logic [2:0] OPL_SHR = 3'b101;
  localparam logic [2:0] OPL_ROL = 3'b110;
  localparam logic [2:0] OPL_ROR = 3'b111;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
endpackage

// File: rtl/alu8_exec_unit_if.sv
// rtl/alu8_exec_unit_if.sv - operand/opcode bundle into the execute stage and its result/flags
interface alu8_exec_unit_if;
  import alu8_pkg::*;

  logic [W-1:0]      a_in;
  logic [W*NREG-1:0] reg_bank;
  logic [BSEL_W-1:0] b_sel;
  logic [W-1:0]      imm;
  logic              irs;
  logic [3:0]        opcode;
  logic              flag_we;
  logic [W-1:0]      result;
  logic [W-1:0]      flags;

  modport master (
    output a_in, reg_bank, b_sel, imm, irs, opcode, flag_we,
    input  result, flags
  );

  modport slave (
    input  a_in, reg_bank, b_sel, imm, irs, opcode, flag_we,
    output result, flags
  );
endinterface

// File: rtl/alu8_bsel.sv
// rtl/alu8_bsel.sv - B operand select: register bank 8:1 mux then immediate 2:1 mux
module alu8_bsel
  import alu8_pkg::*;
(
  input  logic [W*NREG-1:0] i_reg_bank,
  input  logic [BSEL_W-1:0] i_b_sel,
  input  logic [W-1:0]      i_imm,
  input  logic              i_irs,
  output logic [W-1:0]      o_b
);
  logic [W-1:0] w_reg_b;

  // Indexed part-select reads only the chosen byte, so unused entries never reach the result
  assign w_reg_b = i_reg_bank[W*i_b_sel +: W];
  assign o_b     = i_irs ? i_imm : w_reg_b;
endmodule

// File: rtl/alu8_exec_unit.sv
// rtl/alu8_exec_unit.sv - 8-bit ALU with combinational result and registered C/Z/N/V flags
// ALU_SHIFT_BY_B_EN: shift/rotate by B[2:0]; otherwise shift/rotate by a fixed 1
module alu8_exec_unit
  import alu8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu8_exec_unit_if.slave    bus
);
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [2:0]   w_n;
  logic [2:0]   w_n_inv;
  logic         w_n_nz;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W:0]   w_shl;
  logic [W:0]   w_shr;
  logic [W-1:0] w_rol;
  logic [W-1:0] w_ror;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;
  logic [W-1:0] w_flags;
  logic [W-1:0] r_flags;

  assign w_a = bus.a_in;

  alu8_bsel u_bsel (
    .i_reg_bank (bus.reg_bank),
    .i_b_sel    (bus.b_sel),
    .i_imm      (bus.imm),
    .i_irs      (bus.irs),
    .o_b        (w_b)
  );

`ifdef ALU_SHIFT_BY_B_EN
  assign w_n = w_b[2:0];
`else
  assign w_n = 3'd1;
`endif

  assign w_n_nz  = (w_n != 3'd0);
  // (8 - n) mod 8; for n = 0 the rotate ORs A with itself, which passes A through
  assign w_n_inv = 3'd0 - w_n;

  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  // Extra bit catches the last bit shifted out: [8] for SHL, [0] for SHR
  assign w_shl  = {1'b0, w_a} << w_n;
  assign w_shr  = {w_a, 1'b0} >> w_n;
  assign w_rol  = (w_a << w_n) | (w_a >> w_n_inv);
  assign w_ror  = (w_a >> w_n) | (w_a << w_n_inv);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    if (bus.opcode == OP_ADD) begin
      w_res = w_sum[W-1:0];
      w_c   = w_sum[W];
      w_v   = (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1]);
    end else if (bus.opcode == OP_SUB) begin
      w_res = w_diff[W-1:0];
      w_c   = w_diff[W];
      w_v   = (w_a[W-1] != w_b[W-1]) && (w_diff[W-1] != w_a[W-1]);
    end else if (bus.opcode == OP_OR) begin
      w_res = w_a | w_b;
    end else if (bus.opcode == OP_NOR) begin
      w_res = ~(w_a | w_b);
    end else begin
      case (bus.opcode[2:0])
        OPL_XOR: w_res = w_a ^ w_b;
        OPL_AND: w_res = w_a & w_b;
        OPL_SHL: begin
          w_res = w_shl[W-1:0];
          w_c   = w_shl[W];
        end
        OPL_SHR: begin
          w_res = w_shr[W:1];
          w_c   = w_shr[0];
        end
        OPL_ROL: begin
          w_res = w_rol;
          w_c   = w_n_nz & w_rol[0];
        end
        OPL_ROR: begin
          w_res = w_ror;
          w_c   = w_n_nz & w_ror[W-1];
        end
        default: w_res = '0;
      endcase
    end
  end

  always_comb begin
    w_flags        = '0;
    w_flags[FLG_C] = w_c;
    w_flags[FLG_Z] = (w_res == '0);
    w_flags[FLG_N] = w_res[W-1];
    w_flags[FLG_V] = w_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (bus.flag_we) begin
      r_flags <= w_flags;
    end
  end

  assign bus.result = w_res;
  assign bus.flags  = r_flags;
endmodule

// File: tb/tb_alu8_exec_unit.sv
// tb/tb_alu8_exec_unit.sv - directed vector table, reset sequences and randomized model check for alu8_exec_unit
module tb_alu8_exec_unit;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu8_exec_unit_if bus();

  alu8_exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [2:0] bsel;
    logic [7:0] imm;
    logic       irs;
    logic [3:0] op;
    logic       we;
    logic [7:0] res;
    logic [7:0] flg;
  } vec_t;

  vec_t        tv[16];
  logic [63:0] bank;
  logic [7:0]  model_flags;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [63:0] rb, input logic [2:0] bsel,
                       input logic [7:0] imm, input logic irs, input logic [3:0] op, input logic we);
    bus.a_in     = a;
    bus.reg_bank = rb;
    bus.b_sel    = bsel;
    bus.imm      = imm;
    bus.irs      = irs;
    bus.opcode   = op;
    bus.flag_we  = we;
  endtask

  // Reference built from the arithmetic definitions of each operation
  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int r, output logic [7:0] f);
    int n, sa, sb, sr;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    r = 0;
`ifdef ALU_SHIFT_BY_B_EN
    n = b % 8;
`else
    n = 1;
`endif
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    if (op == 0) begin
      r  = (a + b) % 256;
      c  = (a + b) > 255;
      sr = sa + sb;
      v  = (sr > 127) || (sr < -128);
    end else if (op == 8) begin
      r  = (a - b + 256) % 256;
      c  = a < b;
      sr = sa - sb;
      v  = (sr > 127) || (sr < -128);
    end else if (op == 3) begin
      r = a | b;
    end else if (op == 11) begin
      r = 255 - (a | b);
    end else begin
      case (op % 8)
        1: r = a ^ b;
        2: r = a & b;
        4: begin r = (a * (1 << n)) % 256; c = (n > 0) && (((a >> (8 - n)) % 2) == 1); end
        5: begin r = a >> n; c = (n > 0) && (((a >> (n - 1)) % 2) == 1); end
        6: begin r = ((a * (1 << n)) + (a >> (8 - n))) % 256; c = (n > 0) && (r % 2 == 1); end
        7: begin r = ((a >> n) + (a * (1 << (8 - n)))) % 256; c = (n > 0) && (r >= 128); end
        default: r = 0;
      endcase
    end
    f = {4'b0000, v, r >= 128, r == 0, c};
  endfunction

  initial begin
    logic [7:0]  rnd_bytes[8];
    logic [63:0] rb;
    logic [7:0]  ra, rimm, rflg;
    logic [2:0]  rsel;
    logic        rirs, rwe;
    logic [3:0]  rop;
    int          rb_val, rres;

    total = 0;
    bad   = 0;
    bank  = 64'h1066_5544_3322_0700;

    tv[0]  = '{8'h05, 3'd1, 8'h00, 1'b0, 4'b0000, 1'b1, 8'h0C, 8'h00};
    tv[1]  = '{8'h0C, 3'd0, 8'h09, 1'b1, 4'b0000, 1'b1, 8'h15, 8'h00};
    tv[2]  = '{8'h15, 3'd0, 8'h09, 1'b1, 4'b0100, 1'b1, 8'h2A, 8'h00};
    tv[3]  = '{8'h05, 3'd0, 8'h07, 1'b1, 4'b1000, 1'b1, 8'hFE, 8'h05};
    tv[4]  = '{8'h07, 3'd0, 8'h07, 1'b1, 4'b1000, 1'b0, 8'h00, 8'h05};
    tv[5]  = '{8'h0F, 3'd0, 8'hF0, 1'b1, 4'b1011, 1'b1, 8'h00, 8'h02};
    tv[6]  = '{8'h7F, 3'd0, 8'h01, 1'b1, 4'b0000, 1'b1, 8'h80, 8'h0C};
    tv[7]  = '{8'h81, 3'd0, 8'h01, 1'b1, 4'b0111, 1'b1, 8'hC0, 8'h05};
    tv[8]  = '{8'hFF, 3'd0, 8'h01, 1'b1, 4'b0000, 1'b1, 8'h00, 8'h03};
    tv[9]  = '{8'hAA, 3'd0, 8'hFF, 1'b1, 4'b1001, 1'b1, 8'h55, 8'h00};
    tv[10] = '{8'hF0, 3'd0, 8'h3C, 1'b1, 4'b1010, 1'b1, 8'h30, 8'h00};
    tv[11] = '{8'h80, 3'd0, 8'h01, 1'b1, 4'b0011, 1'b1, 8'h81, 8'h04};
    tv[12] = '{8'h03, 3'd0, 8'h01, 1'b1, 4'b0101, 1'b1, 8'h01, 8'h01};
    tv[13] = '{8'h80, 3'd0, 8'h01, 1'b1, 4'b1110, 1'b1, 8'h01, 8'h01};
    tv[14] = '{8'h80, 3'd0, 8'h01, 1'b1, 4'b1000, 1'b1, 8'h7F, 8'h08};
    tv[15] = '{8'h01, 3'd7, 8'hEE, 1'b0, 4'b0000, 1'b1, 8'h11, 8'h00};

    // Reset held with a capturing, nonzero-flag operation presented
    rst_n = 1'b0;
    drive(8'h05, bank, 3'd0, 8'h07, 1'b1, 4'b1000, 1'b1);
    #2;
    chk("reset_flags_initial", bus.flags, 8'h00);
    @(posedge clk);
    #1;
    chk("reset_flags_after_edge", bus.flags, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tv[i].a, bank, tv[i].bsel, tv[i].imm, tv[i].irs, tv[i].op, tv[i].we);
      #1;
      chk($sformatf("vec%0d_result", i), bus.result, tv[i].res);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_flags", i), bus.flags, tv[i].flg);
    end

    // Asynchronous reset in mid-cycle clears flags without waiting for an edge
    @(negedge clk);
    drive(8'h05, bank, 3'd0, 8'h07, 1'b1, 4'b1000, 1'b1);
    @(posedge clk);
    #1;
    chk("async_pre_flags", bus.flags, 8'h05);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_clear_immediate", bus.flags, 8'h00);
    @(posedge clk);
    #1;
    chk("async_hold_over_edge", bus.flags, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_capture_after_release", bus.flags, 8'h05);
    model_flags = 8'h05;

    for (int k = 0; k < 400; k++) begin
      for (int j = 0; j < 8; j++) rnd_bytes[j] = 8'($urandom_range(0, 255));
      for (int j = 0; j < 8; j++) rb[8*j +: 8] = rnd_bytes[j];
      ra   = 8'($urandom_range(0, 255));
      rimm = 8'($urandom_range(0, 255));
      rsel = 3'($urandom_range(0, 7));
      rirs = 1'($urandom_range(0, 1));
      rop  = 4'($urandom_range(0, 15));
      rwe  = 1'($urandom_range(0, 1));
      rb_val = rirs ? int'(rimm) : int'(rnd_bytes[rsel]);
      ref_alu(int'(ra), rb_val, int'(rop), rres, rflg);
      @(negedge clk);
      drive(ra, rb, rsel, rimm, rirs, rop, rwe);
      #1;
      chk($sformatf("rand%0d_op%0h_result", k, rop), bus.result, 8'(rres));
      @(posedge clk);
      #1;
      if (rwe) model_flags = rflg;
      chk($sformatf("rand%0d_op%0h_flags", k, rop), bus.flags, model_flags);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
